// File: rtl/seg_i2c_pkg.sv
// Shared types and constants for the 7-segment display I2C link.
// Both the display driver and the target side import the device address from here.
package seg_i2c_pkg;

    localparam int         NUM_DIGITS   = 4;
    localparam logic [6:0] SEG_DEV_ADDR = 7'h70;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } i2c_tgt_state_e;

endpackage

// File: rtl/seg_i2c_target_if.sv
// I2C bus lines as seen by the display target.
// The master side drives SCL/SDA, and the target side may only pull SDA low.
interface seg_i2c_target_if;

    logic scl_in;
    logic sda_in;
    logic sda_out;
    logic sda_out_en;

    modport master (output scl_in, output sda_in, input sda_out, input sda_out_en);
    modport slave  (input scl_in, input sda_in, output sda_out, output sda_out_en);

endinterface

// File: rtl/seg_i2c_target_line_sync.sv
// Synchronizer chain plus one history flop for a single bus line.
// It provides the clean level and one-cycle rise/fall strobes in the clk domain.
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // An idle I2C line floats high, so reset to 1 to avoid phantom edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else if (sync_reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/seg_i2c_target.sv
// I2C write-only target for the 7-segment controller.
// It captures four digit bytes and commits them on a STOP that ends a complete frame.
module seg_i2c_target
    import seg_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = SEG_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sync_reset,
    seg_i2c_target_if.slave bus,
    output logic [31:0]     digits_flat,
    output logic            frame_valid,
    output logic            frame_err,
    output logic            busy
);

    localparam logic [2:0] BYTE_FULL = 3'(NUM_DIGITS);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_tgt_state_e               state_q, state_d;
    logic [2:0]                   bit_cnt_q, bit_cnt_d;
    logic [7:0]                   shift_q, shift_d;
    logic [7:0]                   byte_next;
    logic [2:0]                   byte_cnt_q, byte_cnt_d;
    logic                         overflow_q, overflow_d;
    logic [NUM_DIGITS-1:0][7:0]   staging_q, staging_d;
    logic [31:0]                  digits_q, digits_d;
    logic                         ack_q, ack_d;
    logic                         busy_q, busy_d;
    logic                         valid_q, valid_d;
    logic                         err_q, err_d;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(rst_n), .sync_reset(sync_reset), .line_in(bus.scl_in),
        .level(scl_level), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(rst_n), .sync_reset(sync_reset), .line_in(bus.sda_in),
        .level(sda_level), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;
    assign byte_next = {shift_q[6:0], sda_level};

    // START/STOP take priority over bit sampling in the same cycle
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        overflow_d = overflow_q;
        staging_d  = staging_q;
        digits_d   = digits_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (start_det) begin
            err_d      = (state_q != ST_IDLE) && (byte_cnt_q != 3'd0);
            staging_d  = '0;
            byte_cnt_d = 3'd0;
            overflow_d = 1'b0;
            bit_cnt_d  = 3'd0;
            ack_d      = 1'b0;
            busy_d     = 1'b1;
            state_d    = ST_ADDR;
        end else if (stop_det) begin
            if (state_q != ST_IDLE) begin
                if (overflow_q || (byte_cnt_q != 3'd0 && byte_cnt_q != BYTE_FULL)) begin
                    err_d = 1'b1;
                end else if (byte_cnt_q == BYTE_FULL) begin
                    valid_d  = 1'b1;
                    digits_d = staging_q;
                end
                byte_cnt_d = 3'd0;
                overflow_d = 1'b0;
                bit_cnt_d  = 3'd0;
                ack_d      = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = (byte_next == {DEV_ADDR, 1'b0}) ? ST_ADDR_ACK : ST_IGNORE;
                        end
                    end
                end
                // First SCL fall pulls SDA low, the next one ends the ACK clock
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            ack_d = 1'b1;
                        end else begin
                            ack_d     = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q < BYTE_FULL) begin
                                staging_d[byte_cnt_q[1:0]] = byte_next;
                                byte_cnt_d = byte_cnt_q + 3'd1;
                                state_d    = ST_DATA_ACK;
                            end else begin
                                overflow_d = 1'b1;
                                state_d    = ST_IGNORE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        if (sync_reset) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            shift_d    = 8'd0;
            byte_cnt_d = 3'd0;
            overflow_d = 1'b0;
            staging_d  = '0;
            digits_d   = 32'd0;
            ack_d      = 1'b0;
            busy_d     = 1'b0;
            valid_d    = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            byte_cnt_q <= 3'd0;
            overflow_q <= 1'b0;
            staging_q  <= '0;
            digits_q   <= 32'd0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            overflow_q <= overflow_d;
            staging_q  <= staging_d;
            digits_q   <= digits_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.sda_out    = 1'b0;
    assign bus.sda_out_en = ack_q;
    assign digits_flat    = digits_q;
    assign frame_valid    = valid_q;
    assign frame_err      = err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_seg_i2c_target.sv
// Directed bench for seg_i2c_target: a bit-banged I2C master with an open-drain SDA model,
// plus pulse counters sampled on the falling clk edge.
module tb_seg_i2c_target;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        scl_drv = 1'b1;
    logic        sda_drv = 1'b1;
    logic [31:0] digits_flat;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int en_cnt = 0;

    seg_i2c_target_if bus_if ();

    assign bus_if.scl_in = scl_drv;
    assign bus_if.sda_in = sda_drv & ~bus_if.sda_out_en;

    seg_i2c_target #(.DEV_ADDR(7'h70), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sync_reset(sync_reset),
        .bus(bus_if),
        .digits_flat(digits_flat),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (frame_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (bus_if.sda_out_en === 1'b1) en_cnt++;
    end

    task automatic tick_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b0; tick_q();
        scl_drv = 1'b0; tick_q();
    endtask

    task automatic i2c_rstart();
        sda_drv = 1'b1; tick_q();
        scl_drv = 1'b1; tick_q();
        sda_drv = 1'b0; tick_q();
        scl_drv = 1'b0; tick_q();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; tick_q();
        scl_drv = 1'b1; tick_q();
        sda_drv = 1'b1; tick_q();
        tick_q();
    endtask

    task automatic i2c_bit(input logic b);
        sda_drv = b;    tick_q();
        scl_drv = 1'b1; tick_q(); tick_q();
        scl_drv = 1'b0; tick_q();
    endtask

    task automatic i2c_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        sda_drv = 1'b1; tick_q();
        scl_drv = 1'b1; tick_q();
        ack = ~bus_if.sda_in;
        tick_q();
        scl_drv = 1'b0; tick_q();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (digits_flat !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_digits: got %h expected %h", digits_flat, 32'd0); end
        n_vec++;
        if ({frame_valid, frame_err, busy, bus_if.sda_out_en} !== 4'b0000) begin
            n_bad++; $display("[TB] FAIL reset_flags: got %b expected 0000", {frame_valid, frame_err, busy, bus_if.sda_out_en});
        end
        rst_n = 1'b1;
        tick_q();
        n_vec++;
        if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_frame();
        logic [7:0] data [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
        logic ack;
        valid_cnt = 0; err_cnt = 0;
        i2c_start();
        n_vec++;
        if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL full_busy_start: got %b expected 1", busy); end
        i2c_byte(8'hE0, ack);
        n_vec++;
        if (ack !== 1'b1) begin n_bad++; $display("[TB] FAIL full_addr_ack: got %b expected 1", ack); end
        for (int i = 0; i < 4; i++) begin
            i2c_byte(data[i], ack);
            n_vec++;
            if (ack !== 1'b1) begin n_bad++; $display("[TB] FAIL full_data_ack%0d: got %b expected 1", i, ack); end
        end
        n_vec++;
        if (busy !== 1'b1 || valid_cnt !== 0) begin
            n_bad++; $display("[TB] FAIL full_pre_stop: busy %b valid %0d expected busy 1 valid 0", busy, valid_cnt);
        end
        i2c_stop();
        n_vec++;
        if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL full_busy_stop: got %b expected 0", busy); end
        n_vec++;
        if (digits_flat !== 32'h4F5B063F) begin n_bad++; $display("[TB] FAIL full_digits: got %h expected 4f5b063f", digits_flat); end
        n_vec++;
        if (valid_cnt !== 1 || err_cnt !== 0) begin
            n_bad++; $display("[TB] FAIL full_pulses: valid %0d err %0d expected 1 0", valid_cnt, err_cnt);
        end
    endtask

    task automatic test_wrong_addr();
        logic ack;
        valid_cnt = 0; err_cnt = 0; en_cnt = 0;
        i2c_start();
        i2c_byte(8'hE2, ack);
        n_vec++;
        if (ack !== 1'b0) begin n_bad++; $display("[TB] FAIL wrong_addr_ack: got %b expected 0", ack); end
        i2c_byte(8'h99, ack);
        n_vec++;
        if (ack !== 1'b0) begin n_bad++; $display("[TB] FAIL wrong_addr_data_ack: got %b expected 0", ack); end
        i2c_stop();
        n_vec++;
        if (en_cnt !== 0) begin n_bad++; $display("[TB] FAIL wrong_addr_sda_en: got %0d cycles expected 0", en_cnt); end
        n_vec++;
        if (digits_flat !== 32'h4F5B063F) begin n_bad++; $display("[TB] FAIL wrong_addr_digits: got %h expected 4f5b063f", digits_flat); end
        n_vec++;
        if (valid_cnt !== 0 || err_cnt !== 0) begin
            n_bad++; $display("[TB] FAIL wrong_addr_pulses: valid %0d err %0d expected 0 0", valid_cnt, err_cnt);
        end
    endtask

    task automatic test_short_frame();
        logic ack;
        valid_cnt = 0; err_cnt = 0;
        i2c_start();
        i2c_byte(8'hE0, ack);
        n_vec++;
        if (ack !== 1'b1) begin n_bad++; $display("[TB] FAIL short_addr_ack: got %b expected 1", ack); end
        i2c_byte(8'h01, ack);
        n_vec++;
        if (ack !== 1'b1) begin n_bad++; $display("[TB] FAIL short_d0_ack: got %b expected 1", ack); end
        i2c_byte(8'h02, ack);
        n_vec++;
        if (ack !== 1'b1) begin n_bad++; $display("[TB] FAIL short_d1_ack: got %b expected 1", ack); end
        i2c_stop();
        n_vec++;
        if (valid_cnt !== 0 || err_cnt !== 1) begin
            n_bad++; $display("[TB] FAIL short_pulses: valid %0d err %0d expected 0 1", valid_cnt, err_cnt);
        end
        n_vec++;
        if (digits_flat !== 32'h4F5B063F) begin n_bad++; $display("[TB] FAIL short_digits: got %h expected 4f5b063f", digits_flat); end
        valid_cnt = 0; err_cnt = 0;
        i2c_start();
        i2c_byte(8'hE0, ack);
        i2c_byte(8'h11, ack);
        i2c_byte(8'h22, ack);
        i2c_byte(8'h33, ack);
        i2c_byte(8'h44, ack);
        n_vec++;
        if (ack !== 1'b1) begin n_bad++; $display("[TB] FAIL short_next_d3_ack: got %b expected 1", ack); end
        i2c_stop();
        n_vec++;
        if (digits_flat !== 32'h44332211 || valid_cnt !== 1 || err_cnt !== 0) begin
            n_bad++; $display("[TB] FAIL short_next_commit: got %h v%0d e%0d expected 44332211 v1 e0", digits_flat, valid_cnt, err_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] data [5] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        logic ack;
        valid_cnt = 0; err_cnt = 0;
        i2c_start();
        i2c_byte(8'hE0, ack);
        for (int i = 0; i < 5; i++) begin
            i2c_byte(data[i], ack);
            n_vec++;
            if (ack !== (i < 4)) begin n_bad++; $display("[TB] FAIL overflow_ack%0d: got %b expected %b", i, ack, (i < 4)); end
        end
        n_vec++;
        if (err_cnt !== 0) begin n_bad++; $display("[TB] FAIL overflow_early_err: got %0d expected 0", err_cnt); end
        i2c_stop();
        n_vec++;
        if (valid_cnt !== 0 || err_cnt !== 1) begin
            n_bad++; $display("[TB] FAIL overflow_pulses: valid %0d err %0d expected 0 1", valid_cnt, err_cnt);
        end
        n_vec++;
        if (digits_flat !== 32'h44332211) begin n_bad++; $display("[TB] FAIL overflow_digits: got %h expected 44332211", digits_flat); end
    endtask

    task automatic test_back_to_back();
        logic ack;
        valid_cnt = 0; err_cnt = 0;
        i2c_start();
        i2c_byte(8'hE0, ack);
        i2c_byte(8'h11, ack);
        i2c_byte(8'h22, ack);
        i2c_rstart();
        n_vec++;
        if (err_cnt !== 1 || valid_cnt !== 0) begin
            n_bad++; $display("[TB] FAIL rstart_err: err %0d valid %0d expected 1 0", err_cnt, valid_cnt);
        end
        n_vec++;
        if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL rstart_busy: got %b expected 1", busy); end
        i2c_byte(8'hE0, ack);
        n_vec++;
        if (ack !== 1'b1) begin n_bad++; $display("[TB] FAIL rstart_addr_ack: got %b expected 1", ack); end
        i2c_byte(8'hAA, ack);
        i2c_byte(8'hBB, ack);
        i2c_byte(8'hCC, ack);
        i2c_byte(8'hDD, ack);
        i2c_stop();
        n_vec++;
        if (digits_flat !== 32'hDDCCBBAA || valid_cnt !== 1 || err_cnt !== 1) begin
            n_bad++; $display("[TB] FAIL rstart_commit: got %h v%0d e%0d expected ddccbbaa v1 e1", digits_flat, valid_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        logic ack;
        i2c_start();
        i2c_byte(8'hE0, ack);
        i2c_byte(8'h01, ack);
        i2c_byte(8'h02, ack);
        for (int i = 0; i < 4; i++) i2c_bit(i[0]);
        valid_cnt = 0; err_cnt = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (digits_flat !== 32'd0 || busy !== 1'b0 || bus_if.sda_out_en !== 1'b0) begin
            n_bad++; $display("[TB] FAIL midreset_outputs: digits %h busy %b en %b expected 0 0 0", digits_flat, busy, bus_if.sda_out_en);
        end
        scl_drv = 1'b1; sda_drv = 1'b1;
        tick_q();
        rst_n = 1'b1;
        tick_q(); tick_q();
        n_vec++;
        if (valid_cnt !== 0 || err_cnt !== 0) begin
            n_bad++; $display("[TB] FAIL midreset_pulses: valid %0d err %0d expected 0 0", valid_cnt, err_cnt);
        end
        i2c_start();
        i2c_byte(8'hE0, ack);
        i2c_byte(8'h78, ack);
        i2c_byte(8'h56, ack);
        i2c_byte(8'h34, ack);
        i2c_byte(8'h12, ack);
        i2c_stop();
        n_vec++;
        if (digits_flat !== 32'h12345678 || valid_cnt !== 1 || err_cnt !== 0) begin
            n_bad++; $display("[TB] FAIL midreset_next: got %h v%0d e%0d expected 12345678 v1 e0", digits_flat, valid_cnt, err_cnt);
        end
    endtask

    task automatic test_sync_reset();
        logic ack;
        valid_cnt = 0; err_cnt = 0;
        i2c_start();
        i2c_byte(8'hE0, ack);
        i2c_byte(8'h5A, ack);
        sync_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sync_reset = 1'b0;
        n_vec++;
        if (digits_flat !== 32'd0 || busy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL sync_reset_state: digits %h busy %b expected 0 0", digits_flat, busy);
        end
        i2c_stop();
        n_vec++;
        if (valid_cnt !== 0 || err_cnt !== 0) begin
            n_bad++; $display("[TB] FAIL sync_reset_pulses: valid %0d err %0d expected 0 0", valid_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_wrong_addr();
        test_short_frame();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_sync_reset();
        n_vec++;
        if (both_cnt !== 0) begin n_bad++; $display("[TB] FAIL pulse_exclusive: got %0d overlap cycles expected 0", both_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
